// File: rtl/mor1kx_wb_retire_marocchino.sv
// Purpose: write-back / retire stage. Latches the execute result, produces the
//          GPR write strobe and retire pulse, and owns SR[F], SR[CY], SR[OV] and FPCSR.
// Latency: 1 cycle from retire to the registered outputs. Forwarding is combinational
//          from the registers. Backpressure: none; padv_wb_i qualifies each retire.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   padv_wb_i, pipeline_flush_i    advance / kill the in-flight retire
//   exec_*                         execute result, destination and SR/FPCSR update requests
//   ctrl_sr_*                      control-unit SR write (mtspr/rfe) and SR[OVE]
//   spr_fpcsr_*                    mtspr to FPCSR
//   dcod_rf{a,b}_adr_i             decode source addresses for forwarding
//   wb_*                           latched result, strobe, retire pulse, SR bits, FPCSR,
//                                  overflow exception pulse and forwarding hits
module mor1kx_wb_retire_marocchino #(
  parameter OPTION_OPERAND_WIDTH = 32,
  parameter OPTION_RF_ADDR_WIDTH = 5,
  parameter FEATURE_OVERFLOW     = "NONE",
  parameter FEATURE_CARRY_FLAG   = "ENABLED",
  parameter FEATURE_FPU          = "NONE"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_wb_i,
  input  logic                            pipeline_flush_i,
  input  logic                            exec_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] exec_result_i,
  input  logic                            exec_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd_adr_i,
  input  logic                            exec_flag_set_i,
  input  logic                            exec_flag_clear_i,
  input  logic                            exec_carry_set_i,
  input  logic                            exec_carry_clear_i,
  input  logic                            exec_overflow_set_i,
  input  logic                            exec_overflow_clear_i,
  input  logic [11:0]                     exec_fpcsr_i,
  input  logic                            exec_fpcsr_set_i,
  input  logic                            ctrl_sr_we_i,
  input  logic                            ctrl_sr_flag_i,
  input  logic                            ctrl_sr_carry_i,
  input  logic                            ctrl_sr_ov_i,
  input  logic                            ctrl_sr_ove_i,
  input  logic                            spr_fpcsr_we_i,
  input  logic [11:0]                     spr_fpcsr_dat_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfb_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o,
  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic                            wb_valid_o,
  output logic                            wb_flag_o,
  output logic                            wb_carry_o,
  output logic                            wb_overflow_o,
  output logic [11:0]                     wb_fpcsr_o,
  output logic                            wb_except_overflow_o,
  output logic                            wb_rfa_fwd_o,
  output logic                            wb_rfb_fwd_o
);

  localparam bit OV_EN  = (FEATURE_OVERFLOW   != "NONE");
  localparam bit CY_EN  = (FEATURE_CARRY_FLAG != "NONE");
  localparam bit FPU_EN = (FEATURE_FPU        != "NONE");

  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_d, wb_result_q;
  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_d, wb_rfd_adr_q;
  logic        wb_rf_wb_d, wb_rf_wb_q;
  logic        wb_valid_d, wb_valid_q;
  logic        wb_flag_d, wb_flag_q;
  logic        wb_carry_d, wb_carry_q;
  logic        wb_overflow_d, wb_overflow_q;
  logic [11:0] wb_fpcsr_d, wb_fpcsr_q;
  logic        wb_except_ov_d, wb_except_ov_q;
  logic        retire;

  // FPU rounding-mode/enable bits of the exec image never accumulate.
  logic unused_fpcsr_low;
  assign unused_fpcsr_low = ^exec_fpcsr_i[2:0];

  assign retire = padv_wb_i & exec_valid_i & ~pipeline_flush_i;

  always_comb begin
    wb_result_d    = wb_result_q;
    wb_rfd_adr_d   = wb_rfd_adr_q;
    wb_rf_wb_d     = retire & exec_rf_wb_i;
    wb_valid_d     = retire;
    wb_flag_d      = wb_flag_q;
    wb_carry_d     = wb_carry_q;
    wb_overflow_d  = wb_overflow_q;
    wb_fpcsr_d     = wb_fpcsr_q;
    wb_except_ov_d = OV_EN & retire & exec_overflow_set_i & ctrl_sr_ove_i;

    if (retire) begin
      wb_result_d  = exec_result_i;
      wb_rfd_adr_d = exec_rfd_adr_i;
    end

    // SR bits: control-unit write beats execute; set beats clear.
    if (ctrl_sr_we_i)                    wb_flag_d = ctrl_sr_flag_i;
    else if (retire & exec_flag_set_i)   wb_flag_d = 1'b1;
    else if (retire & exec_flag_clear_i) wb_flag_d = 1'b0;

    if (ctrl_sr_we_i)                     wb_carry_d = ctrl_sr_carry_i;
    else if (retire & exec_carry_set_i)   wb_carry_d = 1'b1;
    else if (retire & exec_carry_clear_i) wb_carry_d = 1'b0;
    if (!CY_EN) wb_carry_d = 1'b0;

    if (ctrl_sr_we_i)                        wb_overflow_d = ctrl_sr_ov_i;
    else if (retire & exec_overflow_set_i)   wb_overflow_d = 1'b1;
    else if (retire & exec_overflow_clear_i) wb_overflow_d = 1'b0;
    if (!OV_EN) wb_overflow_d = 1'b0;

    // Sticky flags OR-accumulate; mtspr replaces the whole register.
    if (spr_fpcsr_we_i)
      wb_fpcsr_d = spr_fpcsr_dat_i;
    else if (retire & exec_fpcsr_set_i)
      wb_fpcsr_d[11:3] = wb_fpcsr_q[11:3] | exec_fpcsr_i[11:3];
    if (!FPU_EN) wb_fpcsr_d = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_result_q    <= '0;
      wb_rfd_adr_q   <= '0;
      wb_rf_wb_q     <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_flag_q      <= 1'b0;
      wb_carry_q     <= 1'b0;
      wb_overflow_q  <= 1'b0;
      wb_fpcsr_q     <= 12'h000;
      wb_except_ov_q <= 1'b0;
    end else begin
      wb_result_q    <= wb_result_d;
      wb_rfd_adr_q   <= wb_rfd_adr_d;
      wb_rf_wb_q     <= wb_rf_wb_d;
      wb_valid_q     <= wb_valid_d;
      wb_flag_q      <= wb_flag_d;
      wb_carry_q     <= wb_carry_d;
      wb_overflow_q  <= wb_overflow_d;
      wb_fpcsr_q     <= wb_fpcsr_d;
      wb_except_ov_q <= wb_except_ov_d;
    end
  end

  assign wb_result_o          = wb_result_q;
  assign wb_rfd_adr_o         = wb_rfd_adr_q;
  assign wb_rf_wb_o           = wb_rf_wb_q;
  assign wb_valid_o           = wb_valid_q;
  assign wb_flag_o            = wb_flag_q;
  assign wb_carry_o           = wb_carry_q;
  assign wb_overflow_o        = wb_overflow_q;
  assign wb_fpcsr_o           = wb_fpcsr_q;
  assign wb_except_overflow_o = wb_except_ov_q;

  // r0 is hard-wired zero, so a write to it must never be forwarded.
  assign wb_rfa_fwd_o = wb_rf_wb_q & (wb_rfd_adr_q == dcod_rfa_adr_i) & (wb_rfd_adr_q != '0);
  assign wb_rfb_fwd_o = wb_rf_wb_q & (wb_rfd_adr_q == dcod_rfb_adr_i) & (wb_rfd_adr_q != '0);

endmodule

// File: doc/mor1kx_wb_retire_marocchino.md
MOR1KX_WB_RETIRE_MAROCCHINO -- requirements
Module: mor1kx_wb_retire_marocchino

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32: result/data width (W).
REQ-002 SHALL have parameter OPTION_RF_ADDR_WIDTH, default 5: GPR address width (A).
REQ-003 SHALL have parameter FEATURE_OVERFLOW, default "NONE": "NONE" ties SR[OV] and the overflow exception to 0.
REQ-004 SHALL have parameter FEATURE_CARRY_FLAG, default "ENABLED": "NONE" ties SR[CY] to 0.
REQ-005 SHALL have parameter FEATURE_FPU, default "NONE": "NONE" ties the FPCSR register to 0.
REQ-006 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  in  1  clock; reset rst, synchronous, active-high; clock clk
  rst  in  1  synchronous active-high reset
  padv_wb_i  in  1  advance execute->writeback
  pipeline_flush_i  in  1  flush, kills the in-flight retire
  exec_valid_i  in  1  execute result ready
  exec_result_i  in  W  non-latched execute result
  exec_rf_wb_i  in  1  instruction writes a GPR
  exec_rfd_adr_i  in  A  destination GPR
  exec_flag_set_i / exec_flag_clear_i  in  1 each  SR[F] update requests
  exec_carry_set_i / exec_carry_clear_i  in  1 each  SR[CY] update requests
  exec_overflow_set_i / exec_overflow_clear_i  in  1 each  SR[OV] update requests
  exec_fpcsr_i  in  12  FPCSR flag image from the FPU
  exec_fpcsr_set_i  in  1  FPU result completed
  ctrl_sr_we_i  in  1  control-unit SR write (mtspr/rfe)
  ctrl_sr_flag_i, ctrl_sr_carry_i, ctrl_sr_ov_i  in  1 each  SR values to write
  ctrl_sr_ove_i  in  1  SR[OVE], overflow exception enable
  spr_fpcsr_we_i  in  1  mtspr to FPCSR
  spr_fpcsr_dat_i  in  12  FPCSR write data
  dcod_rfa_adr_i, dcod_rfb_adr_i  in  A  decode source addresses
  wb_result_o  out  W  latched result
  wb_rf_wb_o  out  1  GPR write strobe
  wb_rfd_adr_o  out  A  GPR write address
  wb_valid_o  out  1  one-cycle instruction-retired pulse
  wb_flag_o, wb_carry_o, wb_overflow_o  out  1 each  architectural SR[F], SR[CY], SR[OV]
  wb_fpcsr_o  out  12  FPCSR register
  wb_except_overflow_o  out  1  range-exception pulse
  wb_rfa_fwd_o, wb_rfb_fwd_o  out  1 each  forward wb_result_o to decode operand A/B

Function
REQ-007 SHALL define "retire" as padv_wb_i & exec_valid_i & ~pipeline_flush_i.
REQ-008 On retire, SHALL register wb_result_o<=exec_result_i, wb_rfd_adr_o<=exec_rfd_adr_i, wb_rf_wb_o<=exec_rf_wb_i, and wb_valid_o<=1, all visible in the next cycle (1-cycle latency).
REQ-009 In any cycle without a retire, SHALL clear wb_rf_wb_o and wb_valid_o; wb_result_o and wb_rfd_adr_o SHALL hold.
REQ-010 SHALL make wb_rf_wb_o a single-cycle strobe per retired instruction; back-to-back retires SHALL produce consecutive strobes.
REQ-011 SR[F] priority, highest first: ctrl_sr_we_i loads ctrl_sr_flag_i; else on retire, set takes 1 and clear takes 0, with set winning if both are asserted; else hold.
REQ-012 SR[CY] SHALL follow the same priority using the carry inputs; it SHALL be constant 0 when FEATURE_CARRY_FLAG="NONE".
REQ-013 SR[OV] SHALL follow the same priority using the overflow inputs; it SHALL be constant 0 when FEATURE_OVERFLOW="NONE".
REQ-014 wb_except_overflow_o SHALL pulse for one cycle after a retire with exec_overflow_set_i & ctrl_sr_ove_i, but only when FEATURE_OVERFLOW != "NONE".
REQ-015 FPCSR bit 0 (FPEE) and bits 2:1 (RM) SHALL change only through spr_fpcsr_we_i.
REQ-016 FPCSR bits 11:3 (sticky flags) SHALL be OR-accumulated from exec_fpcsr_i[11:3] on each retire with exec_fpcsr_set_i.
REQ-017 spr_fpcsr_we_i SHALL overwrite all 12 FPCSR bits, with priority over accumulation in the same cycle.
REQ-018 wb_rfa_fwd_o SHALL equal wb_rf_wb_o & (wb_rfd_adr_o==dcod_rfa_adr_i) & (wb_rfd_adr_o!=0), combinational from registers only; wb_rfb_fwd_o likewise using dcod_rfb_adr_i.
REQ-019 A flush coincident with padv_wb_i SHALL suppress all retire effects (strobe, flags, FPCSR accumulation, exception), while ctrl_sr_we_i and spr_fpcsr_we_i still take effect.
REQ-020 padv_wb_i with exec_valid_i=0 SHALL behave as an idle cycle.

Reset
REQ-021 With rst=1 at a clk edge, SHALL drive every output register to 0: result, address, strobe, valid, SR[F], SR[CY], SR[OV], FPCSR, exception. This overrides any coincident retire or write, including mid-sequence.
REQ-022 SHALL leave the forwarding outputs at 0 in the cycle after reset.

Verification
REQ-023 Retire result 0xDEADBEEF to r5 with rf_wb=1 -> one cycle later wb_result_o=0xDEADBEEF, wb_rfd_adr_o=5, wb_rf_wb_o=1 and wb_valid_o=1 for exactly one cycle; with dcod_rfa_adr_i=5, wb_rfa_fwd_o=1; with r0 as destination, no forward.
REQ-024 Retire with flag_set and flag_clear both asserted -> wb_flag_o=1; same cycle with ctrl_sr_we_i=1 and ctrl_sr_flag_i=0 -> wb_flag_o=0.
REQ-025 FEATURE_OVERFLOW="ENABLED", OVE=1, retire with overflow_set -> wb_overflow_o=1 and a one-cycle wb_except_overflow_o; repeat with OVE=0 -> overflow set, no exception.
REQ-026 FEATURE_FPU="ENABLED": two retires with exec_fpcsr_i=0x008, then 0x010 -> FPCSR[11:3] holds both bits (0x018); spr write 0x003 in the same cycle as a third accumulation -> FPCSR=0x003.
REQ-027 padv_wb_i, exec_valid_i and pipeline_flush_i asserted together -> no strobe and flags unchanged; rst asserted during back-to-back retires -> all outputs 0 on the next cycle.
